mem_req_arbiter: RTL and testbench

Two-client to one-port memory request arbiter placed directly upstream of the memory server.
- Merges requests from client 0 (e.g. instruction fetch) and client 1 (e.g. data port) onto one `MemIntf` client port.
- Tags each request's opaque field with the originating client and steers responses back by that tag.
- Arbitrates round-robin and limits per-client outstanding transactions.
- The request path is buffered by one register stage so the downstream server never sees a combinational path from client valid to `mem.req_val`.

---
 rtl/mem_req_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Merges two memory clients onto one downstream memory port. Requests are
//   granted round-robin and pass through a single register stage toward the
//   memory server. The top opaque bit of each request is replaced by the
//   originating client id. Responses are steered back to the client named by
//   that bit. Each client may have at most p_max_outstanding requests in
//   flight. A response for a client with nothing outstanding is consumed,
//   dropped, and latches err until reset.
//
// Ports
//   clk, rst_n                  single clock, synchronous active-low reset
//   cli0_* / cli1_*             client ports (server side): req val/rdy/msg in,
//                               resp val/rdy/msg out
//   mem_*                       downstream port (client side): req val/rdy/msg
//                               out, resp val/rdy/msg in
//   err                         sticky protocol-error flag

package mem_msg_pkg;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  // Downstream messages: 8-bit opaque, with the top bit used as the client tag.
  typedef struct packed {
    mem_op_e     op;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } mem_req_8_t;

  typedef struct packed {
    mem_op_e     op;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } mem_resp_8_t;

  // Client-side messages: the opaque field is one bit narrower.
  typedef struct packed {
    mem_op_e     op;
    logic [6:0]  opaque;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } mem_req_7_t;

  typedef struct packed {
    mem_op_e     op;
    logic [6:0]  opaque;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } mem_resp_7_t;

endpackage

module mem_req_arbiter
  import mem_msg_pkg::*;
#(
  parameter type t_req_msg      = mem_req_8_t,
  parameter type t_resp_msg     = mem_resp_8_t,
  parameter type t_cli_req_msg  = mem_req_7_t,
  parameter type t_cli_resp_msg = mem_resp_7_t,
  parameter int  p_opaq_bits       = 8,   // downstream opaque width, >= 2
  parameter int  p_max_outstanding = 4    // per-client in-flight limit, 1..15
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          cli0_req_val,
  output logic          cli0_req_rdy,
  input  t_cli_req_msg  cli0_req_msg,
  output logic          cli0_resp_val,
  input  logic          cli0_resp_rdy,
  output t_cli_resp_msg cli0_resp_msg,

  input  logic          cli1_req_val,
  output logic          cli1_req_rdy,
  input  t_cli_req_msg  cli1_req_msg,
  output logic          cli1_resp_val,
  input  logic          cli1_resp_rdy,
  output t_cli_resp_msg cli1_resp_msg,

  output logic          mem_req_val,
  input  logic          mem_req_rdy,
  output t_req_msg      mem_req_msg,
  input  logic          mem_resp_val,
  output logic          mem_resp_rdy,
  input  t_resp_msg     mem_resp_msg,

  output logic          err
);

  localparam int              CW      = $clog2(p_max_outstanding + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(p_max_outstanding);

  // State
  logic          buf_val;
  t_req_msg      buf_msg;
  logic          last;          // client granted most recently
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  // Request-side combinational signals
  logic          can_accept;
  logic          elig0;
  logic          elig1;
  logic          gnt_val;
  logic          gnt_id;
  t_cli_req_msg  gnt_msg;
  t_req_msg      tag_msg;

  // Response-side combinational signals
  logic          sel;
  logic          sel_busy;
  logic          drop;
  logic          resp_hs0;
  logic          resp_hs1;
  t_cli_resp_msg cli_resp;

  function automatic logic [CW-1:0] step_cnt(input logic [CW-1:0] cur,
                                             input logic          inc,
                                             input logic          dec);
    logic [CW-1:0] nxt;
    nxt = cur;
    case ({inc, dec})
      2'b10:   nxt = cur + CW'(1);
      2'b01:   nxt = cur - CW'(1);
      default: nxt = cur;  // idle, or issue and retire cancel out
    endcase
    return nxt;
  endfunction

  // Arbitration and tagging
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    tag_msg = '0;

    // The slot is free, or it empties this cycle, so a refill is possible.
    can_accept = !buf_val || mem_req_rdy;

    // Comparing against the registered count means a slot freed by a
    // response this cycle cannot be reused until the next cycle.
    elig0 = rst_n && cli0_req_val && (cnt0 < MAX_CNT) && can_accept;
    elig1 = rst_n && cli1_req_val && (cnt1 < MAX_CNT) && can_accept;

    gnt_val = elig0 || elig1;
    gnt_id  = (elig0 && elig1) ? ~last : elig1;

    cli0_req_rdy = gnt_val && !gnt_id;
    cli1_req_rdy = gnt_val &&  gnt_id;

    gnt_msg        = gnt_id ? cli1_req_msg : cli0_req_msg;
    tag_msg.op     = gnt_msg.op;
    tag_msg.opaque = {gnt_id, gnt_msg.opaque[p_opaq_bits-2:0]};
    tag_msg.addr   = gnt_msg.addr;
    tag_msg.strb   = gnt_msg.strb;
    tag_msg.data   = gnt_msg.data;
  end

  assign mem_req_val = buf_val;
  assign mem_req_msg = buf_msg;

  // Response steering
  always_comb begin
    cli_resp = '0;

    sel      = mem_resp_msg.opaque[p_opaq_bits-1];
    sel_busy = sel ? (cnt1 != '0) : (cnt0 != '0);

    // A response for an idle client is consumed here and never forwarded.
    drop = mem_resp_val && !sel_busy;

    cli0_resp_val = mem_resp_val && !sel && sel_busy;
    cli1_resp_val = mem_resp_val &&  sel && sel_busy;
    mem_resp_rdy  = drop || (sel ? cli1_resp_rdy : cli0_resp_rdy);

    resp_hs0 = cli0_resp_val && cli0_resp_rdy;
    resp_hs1 = cli1_resp_val && cli1_resp_rdy;

    cli_resp.op     = mem_resp_msg.op;
    cli_resp.opaque = mem_resp_msg.opaque[p_opaq_bits-2:0];
    cli_resp.addr   = mem_resp_msg.addr;
    cli_resp.strb   = mem_resp_msg.strb;
    cli_resp.data   = mem_resp_msg.data;
  end

  assign cli0_resp_msg = cli_resp;
  assign cli1_resp_msg = cli_resp;

  // Control state
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the edge, independent of order.
    if (!rst_n) begin
      buf_val <= 1'b0;
      last    <= 1'b1;   // client 0 wins the first contention
      cnt0    <= '0;
      cnt1    <= '0;
      err     <= 1'b0;
    end else begin
      if (can_accept) buf_val <= gnt_val;
      if (gnt_val)    last    <= gnt_id;
      cnt0 <= step_cnt(cnt0, cli0_req_rdy, resp_hs0);
      cnt1 <= step_cnt(cnt1, cli1_req_rdy, resp_hs1);
      if (drop) err <= 1'b1;
    end
  end

  // NOTE: the payload register has no reset; buf_val qualifies it, so
  // clearing it would only add reset fan-out to a wide datapath.
  always_ff @(posedge clk) begin
    if (gnt_val) buf_msg <= tag_msg;
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  import mem_msg_pkg::*;

  logic clk;
  logic rst_n;

  // Main instance (p_max_outstanding = 4)
  logic        c0_val, c0_rdy, c0_rval, c0_rrdy;
  logic        c1_val, c1_rdy, c1_rval, c1_rrdy;
  mem_req_7_t  c0_msg, c1_msg;
  mem_resp_7_t c0_rmsg, c1_rmsg;
  logic        m_val, m_rdy, m_rval, m_rrdy, err;
  mem_req_8_t  m_msg;
  mem_resp_8_t m_rmsg;

  // Outstanding-limit instance (p_max_outstanding = 2)
  logic        l0_val, l0_rdy, l0_rval, l0_rrdy;
  logic        l1_val, l1_rdy, l1_rval, l1_rrdy;
  mem_req_7_t  l0_msg, l1_msg;
  mem_resp_7_t l0_rmsg, l1_rmsg;
  logic        lm_val, lm_rdy, lm_rval, lm_rrdy, l_err;
  mem_req_8_t  lm_msg;
  mem_resp_8_t lm_rmsg;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cli0_req_val(c0_val), .cli0_req_rdy(c0_rdy), .cli0_req_msg(c0_msg),
    .cli0_resp_val(c0_rval), .cli0_resp_rdy(c0_rrdy), .cli0_resp_msg(c0_rmsg),
    .cli1_req_val(c1_val), .cli1_req_rdy(c1_rdy), .cli1_req_msg(c1_msg),
    .cli1_resp_val(c1_rval), .cli1_resp_rdy(c1_rrdy), .cli1_resp_msg(c1_rmsg),
    .mem_req_val(m_val), .mem_req_rdy(m_rdy), .mem_req_msg(m_msg),
    .mem_resp_val(m_rval), .mem_resp_rdy(m_rrdy), .mem_resp_msg(m_rmsg),
    .err(err)
  );

  mem_req_arbiter #(.p_max_outstanding(2)) lim (
    .clk(clk), .rst_n(rst_n),
    .cli0_req_val(l0_val), .cli0_req_rdy(l0_rdy), .cli0_req_msg(l0_msg),
    .cli0_resp_val(l0_rval), .cli0_resp_rdy(l0_rrdy), .cli0_resp_msg(l0_rmsg),
    .cli1_req_val(l1_val), .cli1_req_rdy(l1_rdy), .cli1_req_msg(l1_msg),
    .cli1_resp_val(l1_rval), .cli1_resp_rdy(l1_rrdy), .cli1_resp_msg(l1_rmsg),
    .mem_req_val(lm_val), .mem_req_rdy(lm_rdy), .mem_req_msg(lm_msg),
    .mem_resp_val(lm_rval), .mem_resp_rdy(lm_rrdy), .mem_resp_msg(lm_rmsg),
    .err(l_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic mem_req_7_t creq(input mem_op_e op, input logic [6:0] opq,
                                      input logic [31:0] addr, input logic [31:0] data);
    mem_req_7_t r;
    r.op = op; r.opaque = opq; r.addr = addr; r.strb = 4'hF; r.data = data;
    return r;
  endfunction

  function automatic mem_resp_8_t mresp(input mem_op_e op, input logic [7:0] opq,
                                        input logic [31:0] addr, input logic [31:0] data);
    mem_resp_8_t r;
    r.op = op; r.opaque = opq; r.addr = addr; r.strb = 4'hF; r.data = data;
    return r;
  endfunction

  // One well-formed response cycle on the main instance, both clients ready.
  task automatic respond(input string name, input logic [7:0] opq, input logic [31:0] data);
    logic       s;
    logic [6:0] o;
    s = opq[7];
    o = opq[6:0];
    @(negedge clk);
    c0_rrdy = 1'b1;
    c1_rrdy = 1'b1;
    m_rval  = 1'b1;
    m_rmsg  = mresp(MEM_RD, opq, 32'h0000_0100, data);
    #1;
    check({name, "_v0"},   c0_rval, !s);
    check({name, "_v1"},   c1_rval, s);
    check({name, "_mrdy"}, m_rrdy, 1'b1);
    check({name, "_opq"},  s ? c1_rmsg.opaque : c0_rmsg.opaque, o);
    check({name, "_data"}, s ? c1_rmsg.data : c0_rmsg.data, data);
    check({name, "_op"},   s ? c1_rmsg.op : c0_rmsg.op, MEM_RD);
    @(posedge clk);
    #1 m_rval = 1'b0;
  endtask

  typedef struct {
    logic       rval;
    logic [7:0] opq;
    logic       rrdy0;
    logic       rrdy1;
    logic       exp_v0;
    logic       exp_v1;
    logic       exp_mrdy;
    logic [6:0] exp_opq;
  } steer_vec_t;

  steer_vec_t tbl[6];

  initial begin
    // Steering vectors, applied while cnt0 = cnt1 = 1 (no protocol error).
    tbl[0] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'h05};
    tbl[1] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'h05};
    tbl[2] = '{1'b1, 8'h85, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7'h05};
    tbl[3] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'h7F};
    tbl[4] = '{1'b0, 8'h85, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'h05};
    tbl[5] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'h00};

    rst_n  = 1'b0;
    c0_val = 1'b0; c1_val = 1'b0; c0_rrdy = 1'b1; c1_rrdy = 1'b1;
    c0_msg = creq(MEM_RD, 7'h01, 32'h200, 32'h0);
    c1_msg = creq(MEM_RD, 7'h02, 32'h300, 32'h0);
    m_rdy  = 1'b1; m_rval = 1'b0; m_rmsg = mresp(MEM_RD, 8'h00, 32'h0, 32'h0);
    l0_val = 1'b0; l1_val = 1'b0; l0_rrdy = 1'b1; l1_rrdy = 1'b1;
    l0_msg = creq(MEM_WR, 7'h00, 32'h0, 32'h0);
    l1_msg = creq(MEM_WR, 7'h00, 32'h0, 32'h0);
    lm_rdy = 1'b1; lm_rval = 1'b0; lm_rmsg = mresp(MEM_WR, 8'h00, 32'h0, 32'h0);

    // ---- Reset state, with both clients requesting ----
    c0_val = 1'b1; c1_val = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_c0_rdy", c0_rdy, 1'b0);
    check("rst_c1_rdy", c1_rdy, 1'b0);
    check("rst_mem_val", m_val, 1'b0);
    check("rst_err", err, 1'b0);

    // ---- Contention: grants 0,1,0,1 ----
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cont_rdy0_%0d", k), c0_rdy, (k % 2) == 0);
      check($sformatf("cont_rdy1_%0d", k), c1_rdy, (k % 2) == 1);
      if (k > 0)
        check($sformatf("cont_opq_%0d", k), m_msg.opaque, ((k % 2) == 1) ? 8'h01 : 8'h82);
      @(negedge clk);
      #1;
    end
    check("cont_opq_4", m_msg.opaque, 8'h82);
    check("cont_cnt0", dut.cnt0, 3'd2);
    check("cont_cnt1", dut.cnt1, 3'd2);
    c0_val = 1'b0; c1_val = 1'b0;
    @(negedge clk);
    #1;
    check("cont_drained", m_val, 1'b0);
    respond("cont_r0", 8'h01, 32'hA000_0000);
    respond("cont_r1", 8'h82, 32'hA000_0001);
    respond("cont_r2", 8'h01, 32'hA000_0002);
    respond("cont_r3", 8'h82, 32'hA000_0003);
    check("cont_cnt0_end", dut.cnt0, 3'd0);
    check("cont_cnt1_end", dut.cnt1, 3'd0);

    // ---- Single client read ----
    @(negedge clk);
    c0_val = 1'b1;
    c0_msg = creq(MEM_RD, 7'h05, 32'h100, 32'h0);
    #1;
    check("rd_rdy0", c0_rdy, 1'b1);
    check("rd_mem_val_before", m_val, 1'b0);
    @(negedge clk);
    c0_val = 1'b0;
    #1;
    check("rd_mem_val", m_val, 1'b1);
    check("rd_mem_opq", m_msg.opaque, 8'h05);
    check("rd_mem_addr", m_msg.addr, 32'h100);
    check("rd_mem_op", m_msg.op, MEM_RD);
    respond("rd_resp", 8'h05, 32'hDEAD_BEEF);

    // ---- Response steering table (cnt0 = cnt1 = 1) ----
    @(negedge clk);
    c0_val = 1'b1; c1_val = 1'b1;
    c0_msg = creq(MEM_RD, 7'h0A, 32'h10, 32'h0);
    c1_msg = creq(MEM_RD, 7'h0B, 32'h20, 32'h0);
    #1;
    check("st_pre_rdy1", c1_rdy, 1'b1);
    @(negedge clk);
    c1_val = 1'b0;
    #1;
    check("st_pre_rdy0", c0_rdy, 1'b1);
    @(negedge clk);
    c0_val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m_rval  = tbl[i].rval;
      m_rmsg  = mresp(MEM_WR, tbl[i].opq, 32'h40, 32'h1000 + i);
      c0_rrdy = tbl[i].rrdy0;
      c1_rrdy = tbl[i].rrdy1;
      #1;
      check($sformatf("st%0d_v0", i), c0_rval, tbl[i].exp_v0);
      check($sformatf("st%0d_v1", i), c1_rval, tbl[i].exp_v1);
      check($sformatf("st%0d_mrdy", i), m_rrdy, tbl[i].exp_mrdy);
      if (tbl[i].exp_v0 || tbl[i].exp_v1) begin
        check($sformatf("st%0d_opq", i),
              tbl[i].exp_v1 ? c1_rmsg.opaque : c0_rmsg.opaque, tbl[i].exp_opq);
        check($sformatf("st%0d_data", i),
              tbl[i].exp_v1 ? c1_rmsg.data : c0_rmsg.data, 32'h1000 + i);
      end
      #1 m_rval = 1'b0;
    end
    c0_rrdy = 1'b1; c1_rrdy = 1'b1;
    check("st_cnt0", dut.cnt0, 3'd1);
    check("st_cnt1", dut.cnt1, 3'd1);
    respond("st_clr0", 8'h0A, 32'h0);
    respond("st_clr1", 8'h8B, 32'h0);

    // ---- Backpressure ----
    @(negedge clk);
    m_rdy  = 1'b0;
    c0_val = 1'b1; c1_val = 1'b1;
    c0_msg = creq(MEM_RD, 7'h21, 32'h30, 32'h0);
    c1_msg = creq(MEM_RD, 7'h22, 32'h34, 32'h0);
    #1;
    check("bp_first_rdy1", c1_rdy, 1'b1);
    check("bp_first_rdy0", c0_rdy, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp_hold_val_%0d", k), m_val, 1'b1);
      check($sformatf("bp_hold_opq_%0d", k), m_msg.opaque, 8'hA2);
      check($sformatf("bp_hold_rdy0_%0d", k), c0_rdy, 1'b0);
      check($sformatf("bp_hold_rdy1_%0d", k), c1_rdy, 1'b0);
    end
    check("bp_hold_cnt1", dut.cnt1, 3'd1);
    m_rdy = 1'b1;
    #1;
    check("bp_resume_rdy0", c0_rdy, 1'b1);
    @(negedge clk);
    #1;
    check("bp_resume_opq0", m_msg.opaque, 8'h21);
    check("bp_resume_rdy1", c1_rdy, 1'b1);
    @(negedge clk);
    #1;
    check("bp_resume_opq1", m_msg.opaque, 8'hA2);
    check("bp_resume_rdy0b", c0_rdy, 1'b1);
    c0_val = 1'b0; c1_val = 1'b0;
    respond("bp_r0", 8'hA2, 32'h0);
    respond("bp_r1", 8'h21, 32'h0);
    respond("bp_r2", 8'hA2, 32'h0);
    check("bp_cnt0", dut.cnt0, 3'd0);
    check("bp_cnt1", dut.cnt1, 3'd0);

    // ---- Protocol error ----
    @(negedge clk);
    c1_rrdy = 1'b0;
    m_rval  = 1'b1;
    m_rmsg  = mresp(MEM_RD, 8'h81, 32'h0, 32'h0);
    #1;
    check("perr_v1", c1_rval, 1'b0);
    check("perr_v0", c0_rval, 1'b0);
    check("perr_mrdy", m_rrdy, 1'b1);
    check("perr_err_before", err, 1'b0);
    @(posedge clk);
    #1 m_rval = 1'b0;
    c1_rrdy = 1'b1;
    @(negedge clk);
    #1;
    check("perr_err", err, 1'b1);
    check("perr_cnt0", dut.cnt0, 3'd0);
    check("perr_cnt1", dut.cnt1, 3'd0);
    @(negedge clk);
    #1;
    check("perr_sticky", err, 1'b1);

    // ---- Reset mid-operation ----
    m_rdy  = 1'b0;
    c0_val = 1'b1;
    c0_msg = creq(MEM_RD, 7'h31, 32'h50, 32'h0);
    @(negedge clk);
    c1_val = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("mrst_rdy0", c0_rdy, 1'b0);
    check("mrst_rdy1", c1_rdy, 1'b0);
    @(negedge clk);
    #1;
    check("mrst_mem_val", m_val, 1'b0);
    check("mrst_err", err, 1'b0);
    check("mrst_cnt0", dut.cnt0, 3'd0);
    check("mrst_cnt1", dut.cnt1, 3'd0);
    c0_val = 1'b0; c1_val = 1'b0;
    m_rdy  = 1'b1;
    rst_n  = 1'b1;
    // Late response for the discarded pre-reset request.
    @(negedge clk);
    c0_rrdy = 1'b0;
    m_rval  = 1'b1;
    m_rmsg  = mresp(MEM_RD, 8'h31, 32'h50, 32'h0);
    #1;
    check("late_v0", c0_rval, 1'b0);
    check("late_mrdy", m_rrdy, 1'b1);
    @(posedge clk);
    #1 m_rval = 1'b0;
    c0_rrdy = 1'b1;
    @(negedge clk);
    c0_val = 1'b1; c1_val = 1'b1;
    #1;
    check("late_err", err, 1'b1);
    check("post_rst_rdy0", c0_rdy, 1'b1);
    check("post_rst_rdy1", c1_rdy, 1'b0);
    @(negedge clk);
    #1;
    check("post_rst_opq", m_msg.opaque, 8'h31);
    check("post_rst_rdy1b", c1_rdy, 1'b1);
    c0_val = 1'b0; c1_val = 1'b0;

    // ---- Outstanding limit on the p_max_outstanding=2 instance ----
    @(negedge clk);
    l1_val = 1'b1;
    l1_msg = creq(MEM_WR, 7'h11, 32'h500, 32'hCAFE_0001);
    #1;
    check("lim_rdy_a", l1_rdy, 1'b1);
    @(negedge clk);
    l1_msg = creq(MEM_WR, 7'h12, 32'h504, 32'hCAFE_0002);
    #1;
    check("lim_cnt_1", lim.cnt1, 2'd1);
    check("lim_rdy_b", l1_rdy, 1'b1);
    @(negedge clk);
    l1_msg = creq(MEM_WR, 7'h13, 32'h508, 32'hCAFE_0003);
    #1;
    check("lim_cnt_2", lim.cnt1, 2'd2);
    check("lim_stall_rdy", l1_rdy, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("lim_stall_cnt_%0d", k), lim.cnt1, 2'd2);
      check($sformatf("lim_stall_rdy_%0d", k), l1_rdy, 1'b0);
    end
    @(negedge clk);
    lm_rval = 1'b1;
    lm_rmsg = mresp(MEM_WR, 8'h91, 32'h500, 32'h0);
    #1;
    check("lim_resp_v1", l1_rval, 1'b1);
    check("lim_resp_mrdy", lm_rrdy, 1'b1);
    check("lim_same_cycle_rdy", l1_rdy, 1'b0);
    @(posedge clk);
    #1 lm_rval = 1'b0;
    @(negedge clk);
    #1;
    check("lim_cnt_after_resp", lim.cnt1, 2'd1);
    check("lim_reissue_rdy", l1_rdy, 1'b1);
    @(negedge clk);
    #1;
    check("lim_cnt_refill", lim.cnt1, 2'd2);
    check("lim_refill_rdy", l1_rdy, 1'b0);
    check("lim_third_opq", lm_msg.opaque, 8'h93);
    check("lim_err", l_err, 1'b0);
    l1_val = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
